mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory port between the I-cache and the D-cache.
// Each granted line transfer runs to completion (GRANT -> DONE) before the next grant.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_read,
  input  logic              I_write,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic              I_ready,
  output logic [DATA_W-1:0] I_rdata,
  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic              D_ready,
  output logic [DATA_W-1:0] D_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_req_s, d_req_s;

  assign i_req_s = I_read | I_write;
  assign d_req_s = D_read | D_write;

  // Next-state / next-output logic; a write wins over a simultaneous read on the same side.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_s && (!d_req_s || last_d_q)) begin
          state_d     = ST_GRANT_I;
          mem_write_d = I_write;
          mem_read_d  = I_read & ~I_write;
          mem_addr_d  = I_addr;
          mem_wdata_d = I_wdata;
          last_d_d    = 1'b0;
        end else if (d_req_s) begin
          state_d     = ST_GRANT_D;
          mem_write_d = D_write;
          mem_read_d  = D_read & ~D_write;
          mem_addr_d  = D_addr;
          mem_wdata_d = D_wdata;
          last_d_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (mem_ready) begin
          state_d     = ST_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // Only a completed read refreshes the granted side's line buffer.
          if (state_q == ST_GRANT_I) begin
            i_ready_d = 1'b1;
            if (mem_read_q) begin
              i_rdata_d = mem_rdata;
            end else begin
              i_rdata_d = i_rdata_q;
            end
          end else begin
            d_ready_d = 1'b1;
            if (mem_read_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last grant resets to D so the first tie goes to I.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_d_q    <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign I_ready   = i_ready_q;
  assign D_ready   = d_ready_q;
  assign I_rdata   = i_rdata_q;
  assign D_rdata   = d_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference of the shared memory port.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst;
  logic I_read, I_write, D_read, D_write;
  logic [AW-1:0] I_addr, D_addr;
  logic [DW-1:0] I_wdata, D_wdata;
  logic I_ready, D_ready;
  logic [DW-1:0] I_rdata, D_rdata;
  logic mem_read, mem_write, mem_ready, mem_busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .I_read(I_read), .I_write(I_write), .I_addr(I_addr), .I_wdata(I_wdata),
    .I_ready(I_ready), .I_rdata(I_rdata),
    .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_ready(D_ready), .D_rdata(D_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference: port owner (-1 none, 0 I, 1 D), side shown as finished, last granted side
  int m_own, m_done, m_last;
  logic e_mread, e_mwrite, e_iready, e_dready, e_busy;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mwdata, e_irdata, e_drdata;

  bit act_i, rd_i, wr_i, act_d, rd_d, wr_d;
  logic [AW-1:0] addr_i, addr_d;
  logic [DW-1:0] wd_i, wd_d;

  bit mem_auto = 1'b1;
  bit rand_lat = 1'b0;
  bit spur_en = 1'b0;
  bit tx_open = 1'b0;
  int fixed_lat = 1;
  int wait_left = 0;
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  int cnt_mread, cnt_mwrite, cnt_iready, cnt_dready, cnt_busy;
  int g_overlap = 0;
  int g_both_ready = 0;
  logic [AW-1:0] glog_addr[$];
  int glog_cyc[$];
  int last_iready_cyc = 0;
  logic prev_strobe = 1'b0;

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [DW-1:0] mem_lookup(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a, ~a, a, ~a, 16'hC0DE};
  endfunction

  task automatic apply_reqs();
    I_read  = act_i & rd_i;
    I_write = act_i & wr_i;
    I_addr  = addr_i;
    I_wdata = wd_i;
    D_read  = act_d & rd_d;
    D_write = act_d & wr_d;
    D_addr  = addr_d;
    D_wdata = wd_d;
  endtask

  // memory answers after a per-transfer latency; writes land in the memory array
  task automatic respond();
    if (!mem_auto) return;
    mem_ready = 1'b0;
    mem_rdata = rand128();
    if (e_mread || e_mwrite) begin
      if (!tx_open) begin
        tx_open = 1'b1;
        wait_left = rand_lat ? int'($urandom_range(1, 4)) - 1 : fixed_lat - 1;
      end
      if (wait_left == 0) begin
        mem_ready = 1'b1;
        tx_open = 1'b0;
        if (e_mread) mem_rdata = mem_lookup(e_maddr);
        else mem_model[e_maddr] = e_mwdata;
      end else begin
        wait_left--;
      end
    end else if (spur_en && $urandom_range(0, 15) == 0) begin
      mem_ready = 1'b1;
    end
  endtask

  task automatic model_advance();
    bit pi, pd;
    int pick;
    if (rst) begin
      m_own = -1; m_done = -1; m_last = 1;
      e_mread = 1'b0; e_mwrite = 1'b0; e_maddr = '0; e_mwdata = '0;
      e_iready = 1'b0; e_dready = 1'b0; e_irdata = '0; e_drdata = '0; e_busy = 1'b0;
    end else if (m_done >= 0) begin
      e_iready = 1'b0; e_dready = 1'b0; m_done = -1; e_busy = 1'b0;
    end else if (m_own >= 0) begin
      if (mem_ready) begin
        if (e_mread) begin
          if (m_own == 0) e_irdata = mem_rdata;
          else e_drdata = mem_rdata;
        end
        e_mread = 1'b0; e_mwrite = 1'b0;
        e_iready = (m_own == 0); e_dready = (m_own == 1);
        m_done = m_own; m_own = -1;
      end
    end else begin
      pi = I_read | I_write;
      pd = D_read | D_write;
      pick = -1;
      if (pi && pd) pick = 1 - m_last;
      else if (pi) pick = 0;
      else if (pd) pick = 1;
      if (pick == 0) begin
        e_mwrite = I_write; e_mread = I_read && !I_write; e_maddr = I_addr; e_mwdata = I_wdata;
      end else if (pick == 1) begin
        e_mwrite = D_write; e_mread = D_read && !D_write; e_maddr = D_addr; e_mwdata = D_wdata;
      end
      if (pick >= 0) begin
        m_own = pick; m_last = pick; e_busy = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    apply_reqs();
    respond();
    model_advance();
    if (rst) tx_open = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_val("mem_busy",  DW'(mem_busy),  DW'(e_busy));
    check_val("mem_read",  DW'(mem_read),  DW'(e_mread));
    check_val("mem_write", DW'(mem_write), DW'(e_mwrite));
    check_val("mem_addr",  DW'(mem_addr),  DW'(e_maddr));
    check_val("mem_wdata", mem_wdata, e_mwdata);
    check_val("I_ready",   DW'(I_ready),   DW'(e_iready));
    check_val("D_ready",   DW'(D_ready),   DW'(e_dready));
    check_val("I_rdata",   I_rdata, e_irdata);
    check_val("D_rdata",   D_rdata, e_drdata);
    if ((mem_read || mem_write) && !prev_strobe) begin
      glog_addr.push_back(mem_addr);
      glog_cyc.push_back(cyc);
    end
    prev_strobe = mem_read | mem_write;
    if (I_ready) last_iready_cyc = cyc;
    cnt_mread  += int'(mem_read);
    cnt_mwrite += int'(mem_write);
    cnt_iready += int'(I_ready);
    cnt_dready += int'(D_ready);
    cnt_busy   += int'(mem_busy);
    g_overlap    += int'(mem_read & mem_write);
    g_both_ready += int'(I_ready & D_ready);
  endtask

  task automatic clr_stats();
    cnt_mread = 0; cnt_mwrite = 0; cnt_iready = 0; cnt_dready = 0; cnt_busy = 0;
    glog_addr.delete();
    glog_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    act_i = 1'b0;
    act_d = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    clr_stats();
  endtask

  // run until both requesters are served and the port is idle, or until target grants seen
  task automatic serve(input string tag, input int max_cyc, input bit keep, input int target);
    bit ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      cycle();
      if (keep) begin
        if (glog_addr.size() >= target) begin
          ok = 1'b1;
          break;
        end
      end else begin
        if (e_iready) act_i = 1'b0;
        if (e_dready) act_d = 1'b0;
        if (!act_i && !act_d && m_own < 0 && m_done < 0) begin
          ok = 1'b1;
          break;
        end
      end
    end
    check_val({tag, "_completed"}, DW'(ok), DW'(1'b1));
  endtask

  initial begin
    int r;
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    act_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0; addr_i = '0; wd_i = '0;
    act_d = 1'b0; rd_d = 1'b0; wr_d = 1'b0; addr_d = '0; wd_d = '0;
    do_reset();

    // single I read, 3-cycle memory latency
    mem_model[28'h0000010] = 128'hDEADBEEF_00000000_00000000_00000001;
    fixed_lat = 3;
    act_i = 1'b1; rd_i = 1'b1; wr_i = 1'b0; addr_i = 28'h0000010; wd_i = rand128();
    serve("t1", 20, 1'b0, 0);
    check_val("t1_mread_cycles", DW'(cnt_mread), DW'(3));
    check_val("t1_iready_pulses", DW'(cnt_iready), DW'(1));
    check_val("t1_dready_pulses", DW'(cnt_dready), DW'(0));
    check_val("t1_irdata", I_rdata, 128'hDEADBEEF_00000000_00000000_00000001);

    // simultaneous I read and D write after reset: I first
    do_reset();
    fixed_lat = 2;
    act_i = 1'b1; rd_i = 1'b1; wr_i = 1'b0; addr_i = 28'h0000030;
    act_d = 1'b1; rd_d = 1'b0; wr_d = 1'b1; addr_d = 28'h0000020;
    wd_d = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
    serve("t2", 40, 1'b0, 0);
    check_val("t2_grants", DW'(glog_addr.size()), DW'(2));
    if (glog_addr.size() >= 2) begin
      check_val("t2_first_grant", DW'(glog_addr[0]), DW'(28'h0000030));
      check_val("t2_second_grant", DW'(glog_addr[1]), DW'(28'h0000020));
      check_val("t2_d_after_i_done", DW'(glog_cyc[1] > last_iready_cyc), DW'(1'b1));
    end
    check_val("t2_mwrite_cycles", DW'(cnt_mwrite), DW'(2));

    // continuous requests from both sides, latency 1: alternate grants, 3 cycles apart
    do_reset();
    fixed_lat = 1;
    act_i = 1'b1; rd_i = 1'b1; wr_i = 1'b0; addr_i = 28'h0000100;
    act_d = 1'b1; rd_d = 1'b1; wr_d = 1'b0; addr_d = 28'h0000200;
    serve("t3", 60, 1'b1, 6);
    act_i = 1'b0; act_d = 1'b0;
    serve("t3_drain", 20, 1'b0, 0);
    check_val("t3_grants", DW'(glog_addr.size() >= 6), DW'(1'b1));
    for (int k = 0; k < 6 && k < glog_addr.size(); k++) begin
      check_val($sformatf("t3_order_%0d", k), DW'(glog_addr[k]),
                DW'((k % 2 == 0) ? 28'h0000100 : 28'h0000200));
      if (k > 0) check_val($sformatf("t3_spacing_%0d", k), DW'(glog_cyc[k] - glog_cyc[k-1]), DW'(3));
    end

    // D read then D read+write together: write only, rdata kept
    do_reset();
    fixed_lat = 2;
    act_d = 1'b1; rd_d = 1'b1; wr_d = 1'b0; addr_d = 28'h0000040;
    serve("t4_load", 20, 1'b0, 0);
    clr_stats();
    act_d = 1'b1; rd_d = 1'b1; wr_d = 1'b1; addr_d = 28'h0000044; wd_d = rand128();
    serve("t4", 20, 1'b0, 0);
    check_val("t4_mread_cycles", DW'(cnt_mread), DW'(0));
    check_val("t4_mwrite_cycles", DW'(cnt_mwrite), DW'(2));
    check_val("t4_dready_pulses", DW'(cnt_dready), DW'(1));
    check_val("t4_drdata_kept", D_rdata, mem_lookup(28'h0000040));

    // reset while GRANT_D with mem_ready arriving: transfer abandoned
    do_reset();
    mem_auto = 1'b0;
    mem_ready = 1'b0;
    act_d = 1'b1; rd_d = 1'b1; wr_d = 1'b0; addr_d = 28'h0000050;
    cycle();
    cycle();
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = rand128(); act_d = 1'b0;
    cycle();
    rst = 1'b0; mem_ready = 1'b0;
    cycle();
    cycle();
    check_val("t5_no_dready", DW'(cnt_dready), DW'(0));
    mem_auto = 1'b1;
    fixed_lat = 1;
    act_d = 1'b1;
    serve("t5_reserve", 20, 1'b0, 0);
    check_val("t5_dready_after", DW'(cnt_dready), DW'(1));
    check_val("t5_drdata", D_rdata, mem_lookup(28'h0000050));

    // spurious mem_ready while idle
    do_reset();
    mem_auto = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k % 2 == 0);
      mem_rdata = rand128();
      cycle();
    end
    mem_ready = 1'b0;
    mem_auto = 1'b1;
    check_val("t6_busy_cycles", DW'(cnt_busy), DW'(0));
    check_val("t6_ready_pulses", DW'(cnt_iready + cnt_dready), DW'(0));

    // randomized traffic with random latency, spurious completions and occasional reset
    do_reset();
    rand_lat = 1'b1;
    spur_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (e_iready) act_i = 1'b0;
      if (e_dready) act_d = 1'b0;
      if (!act_i && $urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 9));
        act_i = 1'b1; rd_i = (r != 8); wr_i = (r >= 8);
        addr_i = AW'($urandom_range(0, 15)); wd_i = rand128();
      end
      if (!act_d && $urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 9));
        act_d = 1'b1; rd_d = (r < 5) || (r >= 8); wr_d = (r >= 5);
        addr_d = AW'($urandom_range(0, 15)); wd_d = rand128();
      end
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    spur_en = 1'b0;
    serve("rand_drain", 40, 1'b0, 0);

    check_val("strobe_overlap", DW'(g_overlap), DW'(0));
    check_val("ready_overlap", DW'(g_both_ready), DW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
